// File: rtl/orb_match_pkg.sv
// Shared types and helpers for the ORB descriptor matcher.
package orb_match_pkg;

  localparam int unsigned ORB_DESC_WIDTH = 256;
  localparam int unsigned ORB_DIST_WIDTH = 16;

  typedef logic [ORB_DESC_WIDTH-1:0] desc_t;
  typedef logic [ORB_DIST_WIDTH-1:0] dist_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StIssue,
    StDrain,
    StEnd
  } streamer_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/popcount_pipe.sv
// Two-stage XOR/popcount: stage 1 counts 8-bit chunks, stage 2 sums them; a tag rides alongside.
module popcount_pipe import orb_match_pkg::*; #(
  parameter int unsigned DESC_WIDTH = ORB_DESC_WIDTH,
  parameter int unsigned DIST_WIDTH = ORB_DIST_WIDTH,
  parameter int unsigned TAG_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [DESC_WIDTH-1:0] i_a,
  input  logic [DESC_WIDTH-1:0] i_b,
  output logic                  o_mid_valid,
  output logic                  o_valid,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [DIST_WIDTH-1:0] o_dist
);

  localparam int unsigned NChunks = DESC_WIDTH / 8;

  if (DESC_WIDTH % 8 != 0) begin : gen_width_check
    $error("popcount_pipe: DESC_WIDTH must be a multiple of 8");
  end

  logic [DESC_WIDTH-1:0] diff;
  logic [3:0]            chunk_q [NChunks];
  logic                  s1_valid_q;
  logic [TAG_WIDTH-1:0]  s1_tag_q;
  logic [DIST_WIDTH-1:0] sum_d;
  logic                  s2_valid_q;
  logic [TAG_WIDTH-1:0]  s2_tag_q;
  logic [DIST_WIDTH-1:0] s2_dist_q;

  assign diff = i_a ^ i_b;

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < NChunks; i++) begin
      sum_d = sum_d + DIST_WIDTH'(chunk_q[i]);
    end
  end

  // Stage-2 data is gated by valid so idle outputs stay at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      for (int unsigned i = 0; i < NChunks; i++) chunk_q[i] <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_dist_q  <= '0;
    end else begin
      s1_valid_q <= i_valid;
      s1_tag_q   <= i_tag;
      for (int unsigned i = 0; i < NChunks; i++) chunk_q[i] <= popcount8(diff[i*8 +: 8]);
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_valid_q ? s1_tag_q : '0;
      s2_dist_q  <= s1_valid_q ? sum_d : '0;
    end
  end

  assign o_mid_valid = s1_valid_q;
  assign o_valid     = s2_valid_q;
  assign o_tag       = s2_tag_q;
  assign o_dist      = s2_dist_q;

endmodule

// File: rtl/hamming_dist_streamer.sv
// Streams Hamming distances between one query and a RAM range as a start/en/end framed stream.
module hamming_dist_streamer import orb_match_pkg::*; #(
  parameter int unsigned DESC_WIDTH = ORB_DESC_WIDTH,
  parameter int unsigned DIST_WIDTH = ORB_DIST_WIDTH,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [DESC_WIDTH-1:0] i_query,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [15:0]           i_count,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DESC_WIDTH-1:0] i_rd_data,
  output logic                  o_start,
  output logic                  o_en,
  output logic [DIST_WIDTH-1:0] o_data,
  output logic [15:0]           o_location,
  output logic                  o_end,
  output logic                  o_busy
);

  if (DIST_WIDTH < $clog2(DESC_WIDTH + 1)) begin : gen_dist_check
    $error("hamming_dist_streamer: DIST_WIDTH too narrow for DESC_WIDTH");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : gen_lat_check
    $error("hamming_dist_streamer: RD_LATENCY must be 1..4");
  end

  streamer_state_e              state_q;
  logic [DESC_WIDTH-1:0]        query_q;
  logic [ADDR_WIDTH-1:0]        base_q;
  logic [15:0]                  count_q;
  logic                         ready_q, busy_q, start_q, end_q;
  logic                         rd_en_q;
  logic [ADDR_WIDTH-1:0]        rd_addr_q;
  logic [15:0]                  rd_idx_q;
  logic [RD_LATENCY-1:0]        tag_vld_q;
  logic [RD_LATENCY-1:0][15:0]  tag_idx_q;
  logic                         mid_valid;
  logic                         pipe_busy;

  // Tag delay line lines the read index up with the returning RAM data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      tag_vld_q[0] <= rd_en_q;
      tag_idx_q[0] <= rd_idx_q;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  popcount_pipe #(
    .DESC_WIDTH (DESC_WIDTH),
    .DIST_WIDTH (DIST_WIDTH),
    .TAG_WIDTH  (16)
  ) u_popcount_pipe (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (tag_vld_q[RD_LATENCY-1]),
    .i_tag       (tag_idx_q[RD_LATENCY-1]),
    .i_a         (query_q),
    .i_b         (i_rd_data),
    .o_mid_valid (mid_valid),
    .o_valid     (o_en),
    .o_tag       (o_location),
    .o_dist      (o_data)
  );

  // When nothing is upstream of stage 2, the current o_en (if any) is the last one.
  assign pipe_busy = rd_en_q | (|tag_vld_q) | mid_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      query_q   <= '0;
      base_q    <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_idx_q  <= '0;
    end else begin
      start_q <= 1'b0;
      end_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_cmd_valid) begin
            query_q <= i_query;
            base_q  <= i_base_addr;
            count_q <= i_count;
            start_q <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          // An empty frame closes right after its start pulse.
          if (count_q == 16'd0) begin
            end_q   <= 1'b1;
            state_q <= StEnd;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= base_q;
            rd_idx_q  <= '0;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (rd_idx_q == count_q - 16'd1) begin
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            rd_idx_q  <= rd_idx_q + 16'd1;
            rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
          end
        end
        StDrain: begin
          if (!pipe_busy) begin
            end_q   <= 1'b1;
            state_q <= StEnd;
          end
        end
        StEnd: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_start     = start_q;
  assign o_end       = end_q;
  assign o_rd_en     = rd_en_q;
  assign o_rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_hamming_dist_streamer.sv
// Directed bench: two streamer instances (read latency 1 and 3) fed from one RAM model.
module tb_hamming_dist_streamer;

  logic         clk, rst;
  logic [255:0] query;
  logic [9:0]   base;
  logic [15:0]  count;
  logic         sel;
  logic         cv1, cv3;

  logic         ready1, rd_en1, start1, en1, end1, busy1;
  logic [9:0]   rd_addr1;
  logic [255:0] rd_data1;
  logic [15:0]  data1, loc1;
  logic         ready3, rd_en3, start3, en3, end3, busy3;
  logic [9:0]   rd_addr3;
  logic [255:0] rd_data3;
  logic [15:0]  data3, loc3;

  logic         m_ready, m_rd_en, m_start, m_en, m_end, m_busy;
  logic [9:0]   m_rd_addr;
  logic [15:0]  m_data, m_loc;

  logic [255:0] ram [1024];
  logic [255:0] d3 [3];

  int errors = 0;
  int checks = 0;

  hamming_dist_streamer #(
    .DESC_WIDTH (256), .DIST_WIDTH (16), .ADDR_WIDTH (10), .RD_LATENCY (1)
  ) dut1 (
    .i_clk (clk), .i_rst (rst), .i_cmd_valid (cv1), .o_cmd_ready (ready1),
    .i_query (query), .i_base_addr (base), .i_count (count),
    .o_rd_en (rd_en1), .o_rd_addr (rd_addr1), .i_rd_data (rd_data1),
    .o_start (start1), .o_en (en1), .o_data (data1), .o_location (loc1),
    .o_end (end1), .o_busy (busy1)
  );

  hamming_dist_streamer #(
    .DESC_WIDTH (256), .DIST_WIDTH (16), .ADDR_WIDTH (10), .RD_LATENCY (3)
  ) dut3 (
    .i_clk (clk), .i_rst (rst), .i_cmd_valid (cv3), .o_cmd_ready (ready3),
    .i_query (query), .i_base_addr (base), .i_count (count),
    .o_rd_en (rd_en3), .o_rd_addr (rd_addr3), .i_rd_data (rd_data3),
    .o_start (start3), .o_en (en3), .o_data (data3), .o_location (loc3),
    .o_end (end3), .o_busy (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data1 <= ram[rd_addr1];
    d3[0]    <= ram[rd_addr3];
    d3[1]    <= d3[0];
    d3[2]    <= d3[1];
  end
  assign rd_data3 = d3[2];

  assign m_ready   = sel ? ready3   : ready1;
  assign m_rd_en   = sel ? rd_en3   : rd_en1;
  assign m_rd_addr = sel ? rd_addr3 : rd_addr1;
  assign m_start   = sel ? start3   : start1;
  assign m_en      = sel ? en3      : en1;
  assign m_data    = sel ? data3    : data1;
  assign m_loc     = sel ? loc3     : loc1;
  assign m_end     = sel ? end3     : end1;
  assign m_busy    = sel ? busy3    : busy1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one command on the selected instance and checks every output cycle by cycle.
  task automatic frame(input logic [9:0] b, input logic [15:0] n, input logic [255:0] q,
                       output logic [15:0] min_d, output logic [15:0] min_loc);
    int lat, last, k;
    logic exp_rd, exp_en;
    logic [9:0] a;
    lat = sel ? 3 : 1;
    @(negedge clk);
    query = q; base = b; count = n;
    if (sel) cv3 = 1'b1; else cv1 = 1'b1;
    check("cmd_ready_idle", 32'(m_ready), 32'd1);
    @(negedge clk);
    cv1 = 1'b0; cv3 = 1'b0;
    check("start", 32'(m_start), 32'd1);
    check("en_in_start", 32'(m_en), 32'd0);
    check("rd_en_in_start", 32'(m_rd_en), 32'd0);
    last = (n == 16'd0) ? 1 : int'(n) + lat + 3;
    min_d = 16'hffff;
    min_loc = 16'd0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      exp_rd = (cyc <= int'(n));
      check("rd_en", 32'(m_rd_en), 32'(exp_rd));
      if (exp_rd) begin
        a = b + 10'(cyc - 1);
        check("rd_addr", 32'(m_rd_addr), 32'(a));
      end
      exp_en = (n != 16'd0) && (cyc >= lat + 3) && (cyc <= int'(n) + lat + 2);
      check("en", 32'(m_en), 32'(exp_en));
      if (exp_en) begin
        k = cyc - lat - 3;
        a = b + 10'(k);
        check("data", 32'(m_data), 32'($countones(q ^ ram[a])));
        check("location", 32'(m_loc), 32'(k));
        if (m_data < min_d) begin
          min_d = m_data;
          min_loc = m_loc;
        end
      end
      check("start_low", 32'(m_start), 32'd0);
      check("end", 32'(m_end), 32'(cyc == last));
      check("busy", 32'(m_busy), 32'd1);
    end
    @(negedge clk);
    check("ready_after_end", 32'(m_ready), 32'd1);
    check("busy_after_end", 32'(m_busy), 32'd0);
    check("end_single", 32'(m_end), 32'd0);
  endtask

  initial begin
    logic [15:0] mn, ml, ref_min, ref_loc;
    logic [255:0] q;
    int starts, ends, s1, e1, s2, en_f1, rds;

    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 3; i++) d3[i] = '0;
    rst = 1'b1; cv1 = 1'b0; cv3 = 1'b0; sel = 1'b0;
    query = '0; base = '0; count = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_start", 32'(start1), 32'd0);
    check("rst_en", 32'(en1), 32'd0);
    check("rst_rd_en", 32'(rd_en1), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready1_after_rst", 32'(ready1), 32'd1);
    check("ready3_after_rst", 32'(ready3), 32'd1);
    check("end_after_rst", 32'(end1), 32'd0);

    // Basic frame, popcounts 5,0,256,7
    ram[10] = 256'h1f;
    ram[11] = '0;
    ram[12] = '1;
    ram[13] = 256'h7f;
    frame(10'd10, 16'd4, '0, mn, ml);
    check("t1_min", 32'(mn), 32'd0);
    check("t1_min_loc", 32'(ml), 32'd1);

    // Empty frames on both latencies
    frame(10'd5, 16'd0, '0, mn, ml);
    sel = 1'b1;
    frame(10'd5, 16'd0, '0, mn, ml);

    // Latency 3 regular frame
    q = {8{32'hdeadbeef}};
    for (int i = 50; i < 55; i++) ram[i] = {8{$urandom}};
    frame(10'd50, 16'd5, q, mn, ml);
    sel = 1'b0;

    // Address wrap
    ram[1022] = 256'hff;
    ram[1023] = 256'h3;
    ram[0]    = {128'd0, {4{32'hffffffff}}};
    ram[1]    = 256'h1;
    frame(10'd1022, 16'd4, '0, mn, ml);
    check("t3_min", 32'(mn), 32'd1);
    check("t3_min_loc", 32'(ml), 32'd3);

    // Reset two cycles into issue
    @(negedge clk);
    query = '0; base = 10'd10; count = 16'd4; cv1 = 1'b1;
    @(negedge clk);
    cv1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_start", 32'(start1), 32'd0);
    check("midrst_en", 32'(en1), 32'd0);
    check("midrst_end", 32'(end1), 32'd0);
    check("midrst_rd_en", 32'(rd_en1), 32'd0);
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_data", 32'(data1), 32'd0);
    check("midrst_loc", 32'(loc1), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("postrst_end", 32'(end1), 32'd0);
      check("postrst_en", 32'(en1), 32'd0);
    end
    check("postrst_ready", 32'(ready1), 32'd1);
    frame(10'd10, 16'd4, '0, mn, ml);
    check("postrst_min", 32'(mn), 32'd0);

    // Back-to-back commands with valid held, latency 3
    sel = 1'b1;
    starts = 0; ends = 0; s1 = -1; e1 = -1; s2 = -1; en_f1 = 0; rds = 0;
    @(negedge clk);
    query = '0; base = 10'd100; count = 16'd2; cv3 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_rd_en) rds++;
      if (m_en && ends == 0) en_f1++;
      if (m_end) begin
        ends++;
        if (ends == 1) e1 = c;
      end
      if (m_start) begin
        starts++;
        if (starts == 1) s1 = c;
        else if (starts == 2) begin
          s2 = c;
          cv3 = 1'b0;
        end
      end
    end
    check("b2b_starts", 32'(starts), 32'd2);
    check("b2b_ends", 32'(ends), 32'd2);
    check("b2b_frame_len", 32'(e1 - s1), 32'd8);
    check("b2b_gap", 32'(s2 - e1 >= 1), 32'd1);
    check("b2b_en_frame1", 32'(en_f1), 32'd2);
    check("b2b_reads", 32'(rds), 32'd4);
    sel = 1'b0;

    // Random scoreboard, 100 candidates
    for (int i = 200; i < 300; i++) ram[i] = {8{$urandom}};
    q = {8{$urandom}};
    ref_min = 16'hffff; ref_loc = 16'd0;
    for (int i = 0; i < 100; i++) begin
      if (16'($countones(q ^ ram[200 + i])) < ref_min) begin
        ref_min = 16'($countones(q ^ ram[200 + i]));
        ref_loc = 16'(i);
      end
    end
    frame(10'd200, 16'd100, q, mn, ml);
    check("rand_min", 32'(mn), 32'(ref_min));
    check("rand_min_loc", 32'(ml), 32'(ref_loc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
